// File: rtl/axi4_lite_cmd_master_pkg.sv
// Shared types and AXI response codes for the AXI4-Lite command master.
package axi4_lite_cmd_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_B,
        RD_A,
        RD_R,
        RSP
    } cmd_master_state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Timeout counter width; a disabled timeout still keeps a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : (($clog2(timeout + 1) < 1) ? 1 : $clog2(timeout + 1));
    endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axi4_lite_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              wvalid;
    logic              wready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              rvalid;
    logic              rready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi4_lite_cmd_master.sv
// Turns single read/write commands into one AXI4-Lite transaction at a time,
// with a per-handshake timeout so an unmapped or hung slave cannot stall the sequencer.
module axi4_lite_cmd_master
    import axi4_lite_cmd_master_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_wr_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [31:0]       cmd_wdata_i,
    input  logic [3:0]        cmd_wstrb_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_rdata_o,
    output logic [1:0]        rsp_resp_o,
    output logic              rsp_timeout_o,
    axi4_lite_if.master       csr_o
);

    localparam int unsigned     CNT_W    = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    cmd_master_state_t  state_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [31:0]        wdata_q;
    logic [3:0]         wstrb_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               aw_done_q;
    logic               w_done_q;
    logic               awvalid_q;
    logic               wvalid_q;
    logic               bready_q;
    logic               arvalid_q;
    logic               rready_q;

    logic aw_hs_c;
    logic w_hs_c;
    logic timeout_c;

    assign aw_hs_c   = awvalid_q & csr_o.awready;
    assign w_hs_c    = wvalid_q & csr_o.wready;
    assign timeout_c = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    assign csr_o.awvalid = awvalid_q;
    assign csr_o.awaddr  = addr_q;
    assign csr_o.awprot  = 3'b000;
    assign csr_o.wvalid  = wvalid_q;
    assign csr_o.wdata   = wdata_q;
    assign csr_o.wstrb   = wstrb_q;
    assign csr_o.bready  = bready_q;
    assign csr_o.arvalid = arvalid_q;
    assign csr_o.araddr  = addr_q;
    assign csr_o.arprot  = 3'b000;
    assign csr_o.rready  = rready_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            cnt_q         <= '0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            cmd_ready_o   <= 1'b1;
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_resp_o    <= AXI_RESP_OKAY;
            rsp_timeout_o <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        addr_q      <= cmd_addr_i;
                        wdata_q     <= cmd_wdata_i;
                        wstrb_q     <= cmd_wstrb_i;
                        cnt_q       <= '0;
                        cmd_ready_o <= 1'b0;
                        if (cmd_wr_i) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                            state_q   <= WR;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= RD_A;
                        end
                    end
                end

                // AW and W complete independently; leave once both have landed.
                WR: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (aw_hs_c) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs_c) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if ((aw_done_q | aw_hs_c) && (w_done_q | w_hs_c)) begin
                        bready_q <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= WR_B;
                    end else if (timeout_c) begin
                        awvalid_q     <= 1'b0;
                        wvalid_q      <= 1'b0;
                        rsp_valid_o   <= 1'b1;
                        rsp_rdata_o   <= '0;
                        rsp_resp_o    <= AXI_RESP_DECERR;
                        rsp_timeout_o <= 1'b1;
                        state_q       <= RSP;
                    end
                end

                WR_B: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (bready_q && csr_o.bvalid) begin
                        bready_q      <= 1'b0;
                        rsp_valid_o   <= 1'b1;
                        rsp_rdata_o   <= '0;
                        rsp_resp_o    <= csr_o.bresp;
                        rsp_timeout_o <= 1'b0;
                        state_q       <= RSP;
                    end else if (timeout_c) begin
                        bready_q      <= 1'b0;
                        rsp_valid_o   <= 1'b1;
                        rsp_rdata_o   <= '0;
                        rsp_resp_o    <= AXI_RESP_DECERR;
                        rsp_timeout_o <= 1'b1;
                        state_q       <= RSP;
                    end
                end

                RD_A: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (arvalid_q && csr_o.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= RD_R;
                    end else if (timeout_c) begin
                        arvalid_q     <= 1'b0;
                        rsp_valid_o   <= 1'b1;
                        rsp_rdata_o   <= '0;
                        rsp_resp_o    <= AXI_RESP_DECERR;
                        rsp_timeout_o <= 1'b1;
                        state_q       <= RSP;
                    end
                end

                RD_R: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (rready_q && csr_o.rvalid) begin
                        rready_q      <= 1'b0;
                        rsp_valid_o   <= 1'b1;
                        rsp_rdata_o   <= csr_o.rdata;
                        rsp_resp_o    <= csr_o.rresp;
                        rsp_timeout_o <= 1'b0;
                        state_q       <= RSP;
                    end else if (timeout_c) begin
                        rready_q      <= 1'b0;
                        rsp_valid_o   <= 1'b1;
                        rsp_rdata_o   <= '0;
                        rsp_resp_o    <= AXI_RESP_DECERR;
                        rsp_timeout_o <= 1'b1;
                        state_q       <= RSP;
                    end
                end

                RSP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o   <= 1'b0;
                        rsp_rdata_o   <= '0;
                        rsp_resp_o    <= AXI_RESP_OKAY;
                        rsp_timeout_o <= 1'b0;
                        cmd_ready_o   <= 1'b1;
                        state_q       <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_cmd_master.sv
// Directed bench for axi4_lite_cmd_master against a small behavioural CSR slave.
module tb_axi4_lite_cmd_master;
    import axi4_lite_cmd_master_pkg::*;

    localparam int unsigned TO = 16;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wr;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;

    int n_total = 0;
    int n_bad   = 0;

    axi4_lite_if #(.ADDR_W(32)) csr_if ();

    axi4_lite_cmd_master #(.ADDR_W(32), .TIMEOUT(TO)) u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_wr_i     (cmd_wr),
        .cmd_addr_i   (cmd_addr),
        .cmd_wdata_i  (cmd_wdata),
        .cmd_wstrb_i  (cmd_wstrb),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_resp_o   (rsp_resp),
        .rsp_timeout_o(rsp_timeout),
        .csr_o        (csr_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural slave: 16 words at 0x00..0x3C, nothing answers above that.
    logic [31:0] mem [16];
    int unsigned aw_stall;
    logic        b_hold;
    logic        r_force;
    logic [1:0]  r_force_resp;
    logic [31:0] r_force_data;
    int unsigned aw_wait;
    logic        got_aw, got_w, b_pend;
    logic [31:0] s_awaddr, s_wdata;
    logic [3:0]  s_wstrb;
    int unsigned aw_hs_n, w_hs_n;

    function automatic logic mapped(input logic [31:0] a);
        return a < 32'h40;
    endfunction

    assign csr_if.awready = mapped(csr_if.awaddr) && (aw_wait >= aw_stall);
    assign csr_if.wready  = 1'b1;
    assign csr_if.arready = mapped(csr_if.araddr);
    assign csr_if.bresp   = AXI_RESP_OKAY;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_wait       <= 0;
            got_aw        <= 1'b0;
            got_w         <= 1'b0;
            b_pend        <= 1'b0;
            csr_if.bvalid <= 1'b0;
            csr_if.rvalid <= 1'b0;
            csr_if.rdata  <= '0;
            csr_if.rresp  <= '0;
        end else begin
            logic        aw_now, w_now;
            logic [31:0] a, d;
            logic [3:0]  s;
            if (csr_if.awvalid && !csr_if.awready) aw_wait <= aw_wait + 1;
            else aw_wait <= 0;
            aw_now = got_aw | (csr_if.awvalid & csr_if.awready);
            w_now  = got_w  | (csr_if.wvalid  & csr_if.wready);
            if (csr_if.awvalid && csr_if.awready) begin
                got_aw   <= 1'b1;
                s_awaddr <= csr_if.awaddr;
                aw_hs_n  <= aw_hs_n + 1;
            end
            if (csr_if.wvalid && csr_if.wready) begin
                got_w   <= 1'b1;
                s_wdata <= csr_if.wdata;
                s_wstrb <= csr_if.wstrb;
                w_hs_n  <= w_hs_n + 1;
            end
            if (aw_now && w_now && !b_pend) begin
                a = got_aw ? s_awaddr : csr_if.awaddr;
                d = got_w ? s_wdata : csr_if.wdata;
                s = got_w ? s_wstrb : csr_if.wstrb;
                for (int i = 0; i < 4; i++)
                    if (s[i]) mem[a[5:2]][8*i +: 8] <= d[8*i +: 8];
                b_pend <= 1'b1;
                got_aw <= 1'b0;
                got_w  <= 1'b0;
            end
            if (b_pend && !csr_if.bvalid && !b_hold) csr_if.bvalid <= 1'b1;
            if (csr_if.bvalid && csr_if.bready) begin
                csr_if.bvalid <= 1'b0;
                b_pend        <= 1'b0;
            end
            if (csr_if.rvalid && csr_if.rready) csr_if.rvalid <= 1'b0;
            if (csr_if.arvalid && csr_if.arready) begin
                csr_if.rvalid <= 1'b1;
                csr_if.rdata  <= r_force ? r_force_data : mem[csr_if.araddr[5:2]];
                csr_if.rresp  <= r_force ? r_force_resp : AXI_RESP_OKAY;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Issue one command, hold off the response for `hold` cycles, then consume it.
    task automatic do_cmd(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb, input int hold,
                          output logic [31:0] rdata, output logic [1:0] resp, output logic to,
                          output int lat, output int both_n, output int aw_only_n, output int ar_n);
        int n;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        check_eq({tag, "_accept"}, 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 0; both_n = 0; aw_only_n = 0; ar_n = 0;
        do begin
            @(negedge clk);
            lat++;
            if (csr_if.awvalid && csr_if.wvalid) both_n++;
            if (csr_if.awvalid && !csr_if.wvalid) aw_only_n++;
            if (csr_if.arvalid) ar_n++;
        end while (!rsp_valid && lat < 100);
        if (!rsp_valid) check_eq({tag, "_rsp_seen"}, 32'(rsp_valid), 32'd1);
        rdata = rsp_rdata; resp = rsp_resp; to = rsp_timeout;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq({tag, "_hold"}, {cmd_ready, rsp_valid, rsp_resp, rsp_timeout, 27'(0)} ^ rsp_rdata,
                     {1'b0, 1'b1, resp, to, 27'(0)} ^ rdata);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check_eq({tag, "_next_ready"}, {31'(0), cmd_ready}, 32'd1);
        check_eq({tag, "_rsp_clear"}, 32'(rsp_valid), 32'd0);
    endtask

    logic [31:0] rd;
    logic [1:0]  rs;
    logic        to;
    int          lat, both_n, aw_only_n, ar_n, aw0, w0, n;
    logic        seen;

    initial begin
        rst = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_wstrb = '0; rsp_ready = 1'b0;
        aw_stall = 0; b_hold = 1'b0; r_force = 1'b0; r_force_resp = '0; r_force_data = '0;
        aw_hs_n = 0; w_hs_n = 0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        #2 rst = 1'b1;
        #10;
        check_eq("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("reset_rsp", {rsp_valid, rsp_timeout, rsp_resp, rsp_rdata[27:0]}, 32'd0);
        check_eq("reset_axi", 32'({csr_if.awvalid, csr_if.wvalid, csr_if.bready,
                                    csr_if.arvalid, csr_if.rready}), 32'd0);
        @(negedge clk); rst = 1'b0;

        // Zero-wait write then read back.
        do_cmd("wr0c", 1'b1, 32'h0C, 32'h12345678, 4'hF, 0, rd, rs, to, lat, both_n, aw_only_n, ar_n);
        check_eq("wr0c_resp", 32'(rs), 32'd0);
        check_eq("wr0c_to", 32'(to), 32'd0);
        check_eq("wr0c_rdata", rd, 32'd0);
        check_eq("wr0c_lat", 32'(lat), 32'd4);
        do_cmd("rd0c", 1'b0, 32'h0C, 32'h0, 4'h0, 0, rd, rs, to, lat, both_n, aw_only_n, ar_n);
        check_eq("rd0c_rdata", rd, 32'h12345678);
        check_eq("rd0c_resp", 32'(rs), 32'd0);
        check_eq("rd0c_lat", 32'(lat), 32'd3);

        // AW stalled 3 cycles: W lands first and its valid must drop on its own.
        aw_stall = 3; aw0 = int'(aw_hs_n); w0 = int'(w_hs_n);
        do_cmd("wrst", 1'b1, 32'h04, 32'hA5A50001, 4'hF, 0, rd, rs, to, lat, both_n, aw_only_n, ar_n);
        aw_stall = 0;
        check_eq("wrst_aw_hs", 32'(int'(aw_hs_n) - aw0), 32'd1);
        check_eq("wrst_w_hs", 32'(int'(w_hs_n) - w0), 32'd1);
        check_eq("wrst_both_cyc", 32'(both_n), 32'd1);
        check_eq("wrst_aw_only_cyc", 32'(aw_only_n), 32'd3);
        check_eq("wrst_resp", 32'(rs), 32'd0);
        check_eq("wrst_lat", 32'(lat), 32'd7);

        // Partial strobe write.
        do_cmd("wrpart", 1'b1, 32'h0C, 32'hFFFFFFFF, 4'b0011, 0, rd, rs, to, lat, both_n, aw_only_n, ar_n);
        check_eq("wrpart_resp", 32'(rs), 32'd0);

        // Read held off by the consumer for 5 cycles.
        do_cmd("rdhold", 1'b0, 32'h04, 32'h0, 4'h0, 5, rd, rs, to, lat, both_n, aw_only_n, ar_n);
        check_eq("rdhold_rdata", rd, 32'hA5A50001);
        do_cmd("rdpart", 1'b0, 32'h0C, 32'h0, 4'h0, 0, rd, rs, to, lat, both_n, aw_only_n, ar_n);
        check_eq("rdpart_rdata", rd, 32'h1234FFFF);

        // Slave error on read.
        r_force = 1'b1; r_force_resp = 2'b10; r_force_data = 32'hDEADBEEF;
        do_cmd("rderr", 1'b0, 32'h08, 32'h0, 4'h0, 0, rd, rs, to, lat, both_n, aw_only_n, ar_n);
        r_force = 1'b0;
        check_eq("rderr_resp", 32'(rs), 32'd2);
        check_eq("rderr_rdata", rd, 32'hDEADBEEF);
        check_eq("rderr_to", 32'(to), 32'd0);

        // Unmapped read times out after TO cycles of arvalid.
        do_cmd("rdto", 1'b0, 32'h1000, 32'h0, 4'h0, 0, rd, rs, to, lat, both_n, aw_only_n, ar_n);
        check_eq("rdto_ar_cycles", 32'(ar_n), 32'd16);
        check_eq("rdto_resp", 32'(rs), 32'd3);
        check_eq("rdto_flag", 32'(to), 32'd1);
        check_eq("rdto_rdata", rd, 32'd0);
        check_eq("rdto_lat", 32'(lat), 32'd17);
        do_cmd("wrafter", 1'b1, 32'h08, 32'hCAFEF00D, 4'hF, 0, rd, rs, to, lat, both_n, aw_only_n, ar_n);
        check_eq("wrafter_resp", 32'(rs), 32'd0);
        check_eq("wrafter_to", 32'(to), 32'd0);

        // Reset pulsed while waiting for B.
        b_hold = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'h55AA55AA; cmd_wstrb = 4'hF;
        check_eq("rstmid_accept", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n = 0;
        while (!csr_if.bready && n < 20) begin @(negedge clk); n++; end
        check_eq("rstmid_in_wr_b", 32'(csr_if.bready), 32'd1);
        @(negedge clk); rst = 1'b1;
        #1;
        check_eq("rstmid_axi", 32'({csr_if.awvalid, csr_if.wvalid, csr_if.bready,
                                     csr_if.arvalid, csr_if.rready}), 32'd0);
        check_eq("rstmid_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("rstmid_rsp", 32'({rsp_valid, rsp_timeout, rsp_resp}), 32'd0);
        @(negedge clk); rst = 1'b0; b_hold = 1'b0;
        seen = 1'b0;
        repeat (6) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
        check_eq("rstmid_no_rsp", 32'(seen), 32'd0);
        do_cmd("rdrec", 1'b0, 32'h08, 32'h0, 4'h0, 0, rd, rs, to, lat, both_n, aw_only_n, ar_n);
        check_eq("rdrec_rdata", rd, 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
